// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller: FSM states,
// checker verdict encodings and the LFSR feedback polynomial.
package mole_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ARMED,
      RESOLVE,
      GAP,
      OVER
   } state_t;

   localparam logic [1:0] RES_PEND = 2'b00;
   localparam logic [1:0] RES_MISS = 2'b01;
   localparam logic [1:0] RES_HIT  = 2'b11;

   // Taps 8,6,5,4 (x^8+x^6+x^5+x^4+1) as bit positions 7,5,4,3; maximal length.
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/mole_round_controller_if.sv
// Handshake between the round controller (master) and the per-round hit checker (slave).
interface mole_round_controller_if;

   logic [1:0] result;
   logic [1:0] random_num;
   logic       start_checks;
   logic       clock_done;

   modport master (
      input  result,
      output random_num,
      output start_checks,
      output clock_done
   );

   modport slave (
      output result,
      input  random_num,
      input  start_checks,
      input  clock_done
   );

endinterface

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR used to pick the target lane; starts from a non-zero seed.
module mole_lfsr
   import mole_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic [7:0] value
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= SEED;
      end else if (en) begin
         value <= lfsr_next(value);
      end
   end

endmodule

// File: rtl/mole_round_controller.sv
// Whack-a-mole game sequencer: picks lanes, arms the checker, times rounds, keeps score/lives.
// Optional MOLE_SPEEDUP_EN shrinks the reaction window as the score grows.
module mole_round_controller
   import mole_pkg::*;
#(
   parameter int         ROUND_TICKS = 50_000_000,
   parameter int         GAP_TICKS   = 12_500_000,
   parameter int         LIVES_INIT  = 3,
   parameter int         SCORE_W     = 8,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_game,
   mole_round_controller_if.master chk,
   output logic [SCORE_W-1:0]     score,
   output logic [2:0]             lives,
   output logic                   round_active,
   output logic                   game_over
);

   localparam int TW = (ROUND_TICKS > 1) ? $clog2(ROUND_TICKS) : 1;
   localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [TW-1:0] LAST_FULL = TW'(ROUND_TICKS - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);

   state_t        state;
   state_t        state_next;
   logic [TW-1:0] timer;
   logic [TW-1:0] window_last;
   logic [GW-1:0] gap_cnt;
   logic [1:0]    random_num;
   logic [7:0]    lfsr_value;
   logic          lfsr_unused;
   logic          arm;
   logic          window_done;
   logic          hit;
   logic          miss;

   mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .value (lfsr_value)
   );

   assign lfsr_unused = ^lfsr_value[7:2];

   assign hit  = (chk.result == RES_HIT);
   assign miss = (chk.result == RES_MISS);

   assign chk.random_num   = random_num;
   assign chk.start_checks = arm;
   assign chk.clock_done   = window_done;

`ifdef MOLE_SPEEDUP_EN
   // Every 4 hits trims ROUND_TICKS/8 off the window, never below ROUND_TICKS/4.
   function automatic logic [TW-1:0] speed_last(input logic [SCORE_W-1:0] hits);
      int cut;
      int win;
      cut = int'(32'(hits) >> 2) * (ROUND_TICKS / 8);
      win = ROUND_TICKS - cut;
      if (win < ROUND_TICKS / 4) begin
         win = ROUND_TICKS / 4;
      end
      return TW'(win - 1);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         window_last <= LAST_FULL;
      end else if (state == LOAD) begin
         window_last <= speed_last(score);
      end
   end
`else
   assign window_last = LAST_FULL;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      arm          = 1'b0;
      window_done  = 1'b0;
      round_active = 1'b0;
      game_over    = 1'b0;
      case (state)
         IDLE:    if (start_game) state_next = LOAD;
         LOAD:    state_next = ARMED;
         ARMED: begin
            arm          = 1'b1;
            round_active = 1'b1;
            window_done  = (timer == window_last);
            if (hit || miss) state_next = RESOLVE;
         end
         RESOLVE: state_next = (lives == 3'd0) ? OVER : GAP;
         GAP:     if (gap_cnt == GAP_LAST) state_next = LOAD;
         OVER: begin
            game_over = 1'b1;
            if (start_game) state_next = LOAD;
         end
         default: state_next = IDLE;
      endcase
   end

   // Verdicts only count in ARMED, so a checker still reporting after RESOLVE is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer      <= '0;
         gap_cnt    <= '0;
         random_num <= 2'b00;
         score      <= '0;
         lives      <= 3'(LIVES_INIT);
      end else begin
         case (state)
            IDLE, OVER: begin
               if (start_game) begin
                  score <= '0;
                  lives <= 3'(LIVES_INIT);
               end
            end
            LOAD: begin
               random_num <= lfsr_value[1:0];
               timer      <= '0;
            end
            ARMED: begin
               if (timer != window_last) timer <= timer + 1'b1;
               if (hit) begin
                  if (score != '1) score <= score + 1'b1;
               end else if (miss && lives != 3'd0) begin
                  lives <= lives - 3'd1;
               end
            end
            RESOLVE: gap_cnt <= '0;
            GAP:     gap_cnt <= gap_cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mole_round_controller.sv
// Directed self-checking bench for mole_round_controller; the bench plays the hit checker.
module tb_mole_round_controller;
   import mole_pkg::*;

   localparam int         RT   = 20;
   localparam int         GT   = 5;
   localparam int         LI   = 3;
   localparam int         SW   = 3;
   localparam logic [7:0] SEED = 8'hA5;

   logic          clk;
   logic          reset;
   logic          start_game;
   logic [SW-1:0] score;
   logic [2:0]    lives;
   logic          round_active;
   logic          game_over;
   logic [7:0]    m_lfsr;
   logic [7:0]    m_prev;
   int            tests_run;
   int            tests_failed;
   int            first_rise;

   mole_round_controller_if chk ();

   mole_round_controller #(
      .ROUND_TICKS (RT),
      .GAP_TICKS   (GT),
      .LIVES_INIT  (LI),
      .SCORE_W     (SW),
      .LFSR_SEED   (SEED)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start_game   (start_game),
      .chk          (chk.master),
      .score        (score),
      .lives        (lives),
      .round_active (round_active),
      .game_over    (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR; m_prev is the value the DUT saw before the latest edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_lfsr <= SEED;
         m_prev <= SEED;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   function automatic int exp_window(input int hits);
`ifdef MOLE_SPEEDUP_EN
      int w;
      w = RT - (hits / 4) * (RT / 8);
      if (w < RT / 4) w = RT / 4;
      return w;
`else
      return RT + 0 * hits;
`endif
   endfunction

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_stimulus(input logic [1:0] verdict);
      chk.result = verdict;
      tick();
      chk.result = RES_PEND;
   endtask

   task automatic pulse_start();
      start_game = 1'b1;
      tick();
      start_game = 1'b0;
   endtask

   task automatic check_reset_state();
      check_output("rst_score", 32'(score), 0);
      check_output("rst_lives", 32'(lives), LI);
      check_output("rst_random_num", 32'(chk.random_num), 0);
      check_output("rst_start_checks", 32'(chk.start_checks), 0);
      check_output("rst_clock_done", 32'(chk.clock_done), 0);
      check_output("rst_round_active", 32'(round_active), 0);
      check_output("rst_game_over", 32'(game_over), 0);
   endtask

   task automatic wait_armed(input int exp_cycles);
      int n;
      n = 0;
      while (chk.start_checks !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check_output("arm_latency", n, exp_cycles);
      check_output("random_num", 32'(chk.random_num), 32'(m_prev[1:0]));
   endtask

   task automatic measure_timeout(input int exp_rise);
      first_rise = 0;
      for (int k = 1; k <= RT + 1; k++) begin
         tick();
         if (chk.clock_done === 1'b1 && first_rise == 0) first_rise = k;
      end
      check_output("clock_done_rise", first_rise, exp_rise);
      check_output("clock_done_hold", 32'(chk.clock_done), 1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      start_game   = 1'b0;
      chk.result   = RES_PEND;
      repeat (3) tick();
      check_reset_state();
      reset = 1'b0;
      repeat (3) tick();

      // First round: hit held for three cycles must count once.
      pulse_start();
      check_output("load_not_armed", 32'(chk.start_checks), 0);
      wait_armed(1);
      check_output("round_active", 32'(round_active), 1);
      chk.result = RES_HIT;
      tick();
      check_output("hit_disarm", 32'(chk.start_checks), 0);
      check_output("hit_score", 32'(score), 1);
      repeat (2) tick();
      chk.result = RES_PEND;
      check_output("hit_no_double", 32'(score), 1);
      wait_armed(GT);

      // Timeout, then a miss verdict.
      measure_timeout(exp_window(1) - 1);
      apply_stimulus(RES_MISS);
      check_output("miss_lives", 32'(lives), 2);
      check_output("resolve_clock_done", 32'(chk.clock_done), 0);
      check_output("resolve_start_checks", 32'(chk.start_checks), 0);

      wait_armed(GT + 2);
      apply_stimulus(RES_MISS);
      check_output("miss2_lives", 32'(lives), 1);
      wait_armed(GT + 2);
      apply_stimulus(RES_MISS);
      check_output("miss3_lives", 32'(lives), 0);
      tick();
      check_output("over_flag", 32'(game_over), 1);
      check_output("over_start_checks", 32'(chk.start_checks), 0);

      // Stale hits in OVER are ignored.
      chk.result = RES_HIT;
      repeat (4) tick();
      chk.result = RES_PEND;
      check_output("over_score_hold", 32'(score), 1);
      check_output("over_lives_hold", 32'(lives), 0);
      check_output("over_still_idle", 32'(chk.start_checks), 0);

      // Restart from OVER.
      pulse_start();
      check_output("restart_score", 32'(score), 0);
      check_output("restart_lives", 32'(lives), LI);
      check_output("restart_game_over", 32'(game_over), 0);
      wait_armed(1);

      // Reset mid-round at timer=10.
      repeat (10) tick();
      reset = 1'b1;
      tick();
      check_reset_state();
      reset = 1'b0;
      tick();

      // Nine hits saturate a 3-bit score at 7.
      pulse_start();
      wait_armed(1);
      for (int i = 1; i <= 9; i++) begin
         apply_stimulus(RES_HIT);
         check_output("sat_score", 32'(score), (i < 7) ? i : 7);
         wait_armed(GT + 2);
      end
      check_output("sat_lives", 32'(lives), LI);

      // Window after 7 hits (shrinks only with the speedup build).
      measure_timeout(exp_window(7) - 1);
      apply_stimulus(RES_MISS);
      check_output("final_lives", 32'(lives), LI - 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
